// File: rtl/input_port_buffer.sv
// input_port_buffer: receive side of one mesh router input port.
// Captures upstream flits over a req/ack handshake into a small circular
// FIFO. It computes the XY route from the head flit, then requests the
// switch allocator. Once granted, it streams the packet into the switch
// mux. It pops one flit per downstream ack until the tail leaves.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_in, data_in    upstream flit valid / flit (held until ack_in)
//   ack_in             registered one-cycle accept pulse to upstream
//   req_port           allocator request, held for the whole packet
//   rout_port          requested output: 0 local, 1 W, 2 N, 3 E, 4 S
//   grant              allocator grant for this input
//   req_out, data_out  flit valid / FIFO head toward the switch mux
//   ack_out            one-cycle accept pulse from downstream
//
// state | meaning
// IDLE  | no packet open; discard orphan body/tail flits at the head
// REQ   | head seen, route latched, waiting for grant
// SEND  | granted; forward flits until the tail is acked
module input_port_buffer #(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic [17:0] data_in,
  output logic        ack_in,
  output logic        req_port,
  output logic [2:0]  rout_port,
  input  logic        grant,
  output logic        req_out,
  output logic [17:0] data_out,
  input  logic        ack_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [1:0] RX = 2'(ROUTER_X);
  localparam logic [1:0] RY = 2'(ROUTER_Y);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t        state, state_nxt;
  logic [17:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop, load_route;
  logic          is_head, is_tail;
  logic [2:0]    route;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign data_out = empty ? '0 : mem[rd_ptr];

  // Type encoding: bit 0 marks a packet start (head/single), bit 1 a packet
  // end (tail/single).
  assign is_head = data_out[16];
  assign is_tail = data_out[17];

  assign req_port = (state != IDLE);

  // A full FIFO can still take a flit on the edge that pops one, since
  // the slot being written is the one being freed.
  assign push = req_in && !ack_in && (!full || pop);

  always_comb begin
    route = 3'd0;
    if (data_out[15:14] > RX)      route = 3'd3;
    else if (data_out[15:14] < RX) route = 3'd1;
    else if (data_out[13:12] > RY) route = 3'd4;
    else if (data_out[13:12] < RY) route = 3'd2;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_route = 1'b0;
    req_out    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (is_head) begin
            load_route = 1'b1;
            state_nxt  = REQ;
          end else begin
            pop = 1'b1;
          end
        end
      end
      REQ: begin
        if (grant) state_nxt = SEND;
      end
      SEND: begin
        // Losing the grant mid-packet freezes the path without releasing it.
        req_out = grant && !empty;
        if (req_out && ack_out) begin
          pop = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ack_in    <= 1'b0;
      rout_port <= 3'd0;
    end else begin
      state  <= state_nxt;
      ack_in <= push;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (load_route) rout_port <= route;
    end
  end

  // Storage needs no reset: data_out is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in;
  logic [17:0] data_in;
  logic        ack_in;
  logic        req_port;
  logic [2:0]  rout_port;
  logic        grant;
  logic        req_out;
  logic [17:0] data_out;
  logic        ack_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_port_buffer #(.ROUTER_X(1), .ROUTER_Y(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_in(ack_in),
    .req_port(req_port), .rout_port(rout_port), .grant(grant), .req_out(req_out),
    .data_out(data_out), .ack_out(ack_out)
  );

  typedef struct {
    logic [17:0] flit;
    logic [2:0]  rout;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream sender: hold req/data until ack_in is seen, then keep them one
  // more cycle before releasing.
  task automatic send_flit(input logic [17:0] f);
    bit got;
    got     = 1'b0;
    req_in  = 1'b1;
    data_in = f;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack_in) got = 1'b1;
    end
    check_bit("send_ack_seen", got, 1'b1);
    tick();
    req_in = 1'b0;
  endtask

  function automatic logic [17:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [11:0] pl);
    return {t, dx, dy, pl};
  endfunction

  logic [17:0] p [4];
  logic [17:0] d [3];
  logic [17:0] fh, fb1, fb2, fb3, ft, fx, h2, b2x, h3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Router sits at (1,1).
    vecs[0] = '{mk(2'b11, 2'd3, 2'd1, 12'h000), 3'd3};
    vecs[1] = '{mk(2'b11, 2'd0, 2'd1, 12'h5a1), 3'd1};
    vecs[2] = '{mk(2'b11, 2'd1, 2'd3, 12'h0f2), 3'd4};
    vecs[3] = '{mk(2'b11, 2'd1, 2'd0, 12'hc33), 3'd2};
    vecs[4] = '{mk(2'b11, 2'd1, 2'd1, 12'h7e4), 3'd0};
    vecs[5] = '{mk(2'b11, 2'd3, 2'd0, 12'h105), 3'd3};
    vecs[6] = '{mk(2'b11, 2'd0, 2'd3, 12'hfff), 3'd1};
    vecs[7] = '{mk(2'b11, 2'd1, 2'd2, 12'h8a6), 3'd4};

    rst = 1'b1; req_in = 1'b0; data_in = '0; grant = 1'b0; ack_out = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_bit("rst_ack_in", ack_in, 1'b0);
    check_bit("rst_req_port", req_port, 1'b0);
    check_bit("rst_req_out", req_out, 1'b0);
    check_word("rst_rout_port", 18'(rout_port), 18'd0);
    check_word("rst_data_out", data_out, 18'd0);

    // Single-flit packets through the route table.
    for (int v = 0; v < 8; v++) begin
      send_flit(vecs[v].flit);
      check_bit("vec_ack_pulse", ack_in, 1'b0);
      check_bit("vec_req_port", req_port, 1'b1);
      check_word("vec_rout_port", 18'(rout_port), 18'(vecs[v].rout));
      check_bit("vec_req_out_pre", req_out, 1'b0);
      grant = 1'b1;
      tick();
      check_bit("vec_req_out", req_out, 1'b1);
      check_word("vec_data_out", data_out, vecs[v].flit);
      ack_out = 1'b1;
      tick();
      check_bit("vec_req_port_done", req_port, 1'b0);
      check_bit("vec_req_out_done", req_out, 1'b0);
      check_word("vec_empty", data_out, 18'd0);
      ack_out = 1'b0;
      grant = 1'b0;
      tick();
    end

    // Four-flit packet to north, with a grant drop mid-packet.
    p[0] = mk(2'b01, 2'd1, 2'd0, 12'h101);
    p[1] = mk(2'b00, 2'd2, 2'd2, 12'h202);
    p[2] = mk(2'b00, 2'd3, 2'd3, 12'h303);
    p[3] = mk(2'b10, 2'd0, 2'd0, 12'h404);
    for (int i = 0; i < 4; i++) send_flit(p[i]);
    check_bit("pkt_req_port", req_port, 1'b1);
    check_word("pkt_rout_port", 18'(rout_port), 18'd2);
    check_bit("pkt_no_grant", req_out, 1'b0);
    grant = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        grant = 1'b0;
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        check_word("freeze_head", data_out, p[2]);
        check_bit("freeze_req_out", req_out, 1'b0);
        check_bit("freeze_req_port", req_port, 1'b1);
        grant = 1'b1;
        tick();
      end
      check_bit("pkt_req_out", req_out, 1'b1);
      check_word("pkt_data_out", data_out, p[i]);
      ack_out = 1'b1;
      tick();
      ack_out = 1'b0;
      check_bit("pkt_req_port_after_pop", req_port, i < 3);
      tick();
    end
    check_bit("pkt_req_out_end", req_out, 1'b0);
    check_word("pkt_empty", data_out, 18'd0);
    grant = 1'b0;

    // Fill to DEPTH, hold the 5th, then write+pop at full.
    fh  = mk(2'b01, 2'd3, 2'd1, 12'hA01);
    fb1 = mk(2'b00, 2'd0, 2'd0, 12'hA02);
    fb2 = mk(2'b00, 2'd0, 2'd0, 12'hA03);
    fb3 = mk(2'b00, 2'd0, 2'd0, 12'hA04);
    ft  = mk(2'b10, 2'd0, 2'd0, 12'hA05);
    fx  = mk(2'b00, 2'd2, 2'd2, 12'hA06);
    send_flit(fh); send_flit(fb1); send_flit(fb2); send_flit(fb3);
    check_bit("fill_req_port", req_port, 1'b1);
    check_word("fill_rout_port", 18'(rout_port), 18'd3);
    req_in = 1'b1; data_in = ft;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit("full_hold", ack_in, 1'b0);
    end
    grant = 1'b1;
    tick();
    check_bit("full_hold_grant", ack_in, 1'b0);
    check_bit("fill_req_out", req_out, 1'b1);
    check_word("fill_head", data_out, fh);
    ack_out = 1'b1;
    tick();
    ack_out = 1'b0;
    check_bit("simul_ack", ack_in, 1'b1);
    check_word("simul_head", data_out, fb1);
    tick();
    data_in = fx;
    check_bit("simul_pulse", ack_in, 1'b0);
    tick();
    check_bit("still_full", ack_in, 1'b0);
    check_word("still_head", data_out, fb1);
    ack_out = 1'b1;
    tick();
    ack_out = 1'b0;
    check_bit("x_ack", ack_in, 1'b1);
    check_word("x_head", data_out, fb2);
    tick();
    req_in = 1'b0;
    d[0] = fb2; d[1] = fb3; d[2] = ft;
    for (int i = 0; i < 3; i++) begin
      check_word("drain_data", data_out, d[i]);
      ack_out = 1'b1;
      tick();
      ack_out = 1'b0;
      check_bit("drain_req_port", req_port, i < 2);
      if (i < 2) tick();
    end
    // The body flit behind the tail is an orphan once the packet closes.
    check_word("orphan_head", data_out, fx);
    check_bit("orphan_req_out", req_out, 1'b0);
    tick();
    check_word("orphan_gone", data_out, 18'd0);
    check_bit("orphan_req_port", req_port, 1'b0);
    tick();
    check_bit("orphan_req_port2", req_port, 1'b0);
    grant = 1'b0;

    // Local head after the orphan, then reset mid-packet.
    h2  = mk(2'b01, 2'd1, 2'd1, 12'hB01);
    b2x = mk(2'b00, 2'd0, 2'd0, 12'hB02);
    send_flit(h2);
    check_bit("local_req_port", req_port, 1'b1);
    check_word("local_rout_port", 18'(rout_port), 18'd0);
    send_flit(b2x);
    grant = 1'b1;
    tick();
    check_bit("mid_req_out", req_out, 1'b1);
    check_word("mid_head", data_out, h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grant = 1'b0;
    check_bit("mrst_req_port", req_port, 1'b0);
    check_bit("mrst_req_out", req_out, 1'b0);
    check_bit("mrst_ack_in", ack_in, 1'b0);
    check_word("mrst_empty", data_out, 18'd0);
    tick();
    check_bit("mrst_req_port2", req_port, 1'b0);

    h3 = mk(2'b11, 2'd1, 2'd3, 12'hC0D);
    send_flit(h3);
    check_bit("post_req_port", req_port, 1'b1);
    check_word("post_rout_port", 18'(rout_port), 18'd4);
    grant = 1'b1;
    tick();
    check_bit("post_req_out", req_out, 1'b1);
    check_word("post_data", data_out, h3);
    ack_out = 1'b1;
    tick();
    ack_out = 1'b0;
    grant = 1'b0;
    check_bit("post_req_port_done", req_port, 1'b0);
    check_word("post_empty", data_out, 18'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
